// File: rtl/quadrature_input_filter_pkg.sv
// Shared register map, ID prefix and quadrature-step classification
// used by the encoder input filter.
package quadrature_input_filter_pkg;

    localparam logic [2:0]  QIF_ADDR_ID     = 3'd0;
    localparam logic [2:0]  QIF_ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  QIF_ADDR_STAT   = 3'd2;
    localparam logic [2:0]  QIF_ADDR_ERR    = 3'd3;

    localparam int          QIF_CTRL_EN_BIT = 31;

    localparam logic [15:0] QIF_ID_FAMILY   = 16'hEA68;
    localparam logic [15:0] QIF_ID_DEVICE   = 16'h0004;

    typedef enum logic [1:0] {
        QIF_MOVE_NONE,
        QIF_MOVE_FWD,
        QIF_MOVE_REV,
        QIF_MOVE_ILLEGAL
    } qif_move_e;

    // Forward Gray sequence {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] qif_fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic qif_move_e qif_classify(input logic [1:0] prev, input logic [1:0] cur);
        if (prev == cur)
            return QIF_MOVE_NONE;
        else if ((prev ^ cur) == 2'b11)
            return QIF_MOVE_ILLEGAL;
        else if (cur == qif_fwd_next(prev))
            return QIF_MOVE_FWD;
        else
            return QIF_MOVE_REV;
    endfunction

endpackage

// File: rtl/qif_glitch_filter.sv
// One encoder channel: 2-FF synchroniser followed by a persistence filter
// that only passes a level once it has been stable for filt_len+1 cycles.
module qif_glitch_filter #(
    parameter int FILTER_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [FILTER_W-1:0] filt_len,
    input  logic                raw,
    output logic                out
);

    logic                r_sync1;
    logic                r_sync2;
    logic [FILTER_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Counter measures how long the synchronised level has disagreed with out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            out   <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
        end else if (r_sync2 == out) begin
            r_cnt <= '0;
        end else if (r_cnt == filt_len) begin
            out   <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quadrature_input_filter.sv
// Encoder front end: filtered A/B/Z, x4 quadrature decode into step/dir/err,
// and an Avalon-MM register file for configuration and status.
module quadrature_input_filter
    import quadrature_input_filter_pkg::*;
#(
    parameter int          FILTER_W = 8,
    parameter logic [31:0] ID_VALUE = {QIF_ID_FAMILY, QIF_ID_DEVICE}
) (
    input  logic        rsi_MRST_reset,
    input  logic        csi_MCLK_clk,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        A_in,
    input  logic        B_in,
    input  logic        Z_in,
    output logic        A_out,
    output logic        B_out,
    output logic        Z_out,
    output logic        step,
    output logic        dir,
    output logic        err
);

    logic                r_enable;
    logic [FILTER_W-1:0] r_filtLen;
    logic [15:0]         r_errCnt;
    logic [1:0]          r_prev;
    logic                r_wasEn;

    logic [31:0]         w_ctrlCur;
    logic [31:0]         w_ctrlWr;
    logic [31:0]         w_rdMux;
    logic                w_wrCtrl;
    logic                w_wrErr;
    logic [1:0]          w_state;
    qif_move_e           w_move;
    logic                w_unused;

    assign avs_ctrl_waitrequest = 1'b0;

    qif_glitch_filter #(.FILTER_W(FILTER_W)) u_filtA (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .en(r_enable),
        .filt_len(r_filtLen), .raw(A_in), .out(A_out)
    );

    qif_glitch_filter #(.FILTER_W(FILTER_W)) u_filtB (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .en(r_enable),
        .filt_len(r_filtLen), .raw(B_in), .out(B_out)
    );

    qif_glitch_filter #(.FILTER_W(FILTER_W)) u_filtZ (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .en(r_enable),
        .filt_len(r_filtLen), .raw(Z_in), .out(Z_out)
    );

    assign w_state = {A_out, B_out};
    assign w_move  = qif_classify(r_prev, w_state);

    // The first enabled cycle only re-seeds prev, so a re-enable never emits a step.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_prev  <= 2'b00;
            r_wasEn <= 1'b1;
            step    <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_prev  <= w_state;
            r_wasEn <= r_enable;
            step    <= 1'b0;
            err     <= 1'b0;
            if (r_enable && r_wasEn) begin
                case (w_move)
                    QIF_MOVE_FWD: begin
                        step <= 1'b1;
                        dir  <= 1'b1;
                    end
                    QIF_MOVE_REV: begin
                        step <= 1'b1;
                        dir  <= 1'b0;
                    end
                    QIF_MOVE_ILLEGAL: err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign w_ctrlCur = {r_enable, {(QIF_CTRL_EN_BIT - FILTER_W){1'b0}}, r_filtLen};
    assign w_wrCtrl  = avs_ctrl_write && (avs_ctrl_address == QIF_ADDR_CTRL);
    assign w_wrErr   = avs_ctrl_write && (avs_ctrl_address == QIF_ADDR_ERR);
    assign w_unused  = ^{avs_ctrl_read, w_ctrlWr[QIF_CTRL_EN_BIT-1:FILTER_W]};

    always_comb begin
        w_ctrlWr = w_ctrlCur;
        for (int i = 0; i < 4; i++) begin
            if (avs_ctrl_byteenable[i])
                w_ctrlWr[8*i +: 8] = avs_ctrl_writedata[8*i +: 8];
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_enable  <= 1'b1;
            r_filtLen <= FILTER_W'(3);
        end else if (w_wrCtrl) begin
            r_enable  <= w_ctrlWr[QIF_CTRL_EN_BIT];
            r_filtLen <= w_ctrlWr[FILTER_W-1:0];
        end
    end

    // Clear beats a coincident increment.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)
            r_errCnt <= 16'h0000;
        else if (w_wrErr)
            r_errCnt <= 16'h0000;
        else if (err && (r_errCnt != 16'hFFFF))
            r_errCnt <= r_errCnt + 16'h0001;
    end

    always_comb begin
        w_rdMux = 32'h0000_0000;
        case (avs_ctrl_address)
            QIF_ADDR_ID:   w_rdMux = ID_VALUE;
            QIF_ADDR_CTRL: w_rdMux = w_ctrlCur;
            QIF_ADDR_STAT: w_rdMux = {28'h0000000, dir, Z_out, B_out, A_out};
            QIF_ADDR_ERR:  w_rdMux = {16'h0000, r_errCnt};
            default:       w_rdMux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)
            avs_ctrl_readdata <= 32'h0000_0000;
        else
            avs_ctrl_readdata <= w_rdMux;
    end

endmodule

// File: doc/quadrature_input_filter.md
Name: quadrature_input_filter

Overview:
- Front-end conditioning stage for incremental encoder inputs (A, B, Z). Feeds the position counter block.
- Synchronises raw pins into csi_MCLK_clk, removes glitches with a programmable per-channel filter, and produces clean A/B/Z.
- Decodes clean A/B at x4 resolution into single-cycle step/dir pulses and detects illegal transitions.
- Configured and monitored over an Avalon-MM slave on the same Qsys bus as its neighbours.

Parameters:
- FILTER_W, 8: width of the filter-length field and the per-channel filter counters.
- ID_VALUE, 32'hEA680004: constant returned at register address 0.

Ports:
- rsi_MRST_reset  in  1  asynchronous reset, active-high
- csi_MCLK_clk  in  1  system clock
- avs_ctrl_writedata  in  32  register write data
- avs_ctrl_readdata  out  32  register read data
- avs_ctrl_byteenable  in  4  write byte lanes
- avs_ctrl_address  in  3  word address
- avs_ctrl_write  in  1  write strobe
- avs_ctrl_read  in  1  read strobe
- avs_ctrl_waitrequest  out  1  tied 0
- A_in, B_in, Z_in  in  1 each  raw encoder pins, asynchronous to the clock
- A_out, B_out, Z_out  out  1 each  filtered signals, registered
- step  out  1  one-cycle pulse per legal quadrature edge
- dir  out  1  direction of the last legal step: 1 = A leads B
- err  out  1  one-cycle pulse per illegal transition

Behaviour:
- Reset: rsi_MRST_reset is asynchronous and active-high; clock is csi_MCLK_clk. All synchronisers, filter counters, A/B/Z_out, step, dir and err reset to 0. readdata resets to 0, err_cnt to 0, filt_len to 3, enable to 1, and the decoder previous state to 2'b00.
- Synchroniser: 2-FF chain per channel.
- Filter, per channel:
  - When sync equals out, the counter is cleared.
  - When sync differs from out and the counter equals filt_len: out <= sync and the counter is cleared.
  - Otherwise the counter increments.
  - Latency from a raw edge to the *_out change is 2 + filt_len + 1 cycles. filt_len = 0 gives 3 cycles.
  - A pulse shorter than filt_len + 1 synchronised cycles never reaches *_out.
- Decoder:
  - State s = {A_out, B_out}, compared against a registered prev.
  - Forward sequence 00→10→11→01→00 gives step = 1, dir = 1.
  - Reverse sequence gives step = 1, dir = 0.
  - Both bits changing in one cycle gives err = 1, step = 0, and dir is held.
  - prev <= s every cycle.
  - step/err assert in the cycle after *_out changes.
- Z_out is filtered only, never decoded.
- Enable = 0:
  - A/B/Z_out hold their values and step/err are forced to 0.
  - The filter counters are held at 0.
  - On re-enable, prev is loaded from the current {A_out, B_out} in the first enabled cycle with no step or err generated.
- Registers. Read latency is 1 cycle (readdata registered on every clock from avs_ctrl_address); waitrequest is tied 0.
  - addr 0 (RO): ID_VALUE.
  - addr 1 (RW): bit 31 = enable, bits [FILTER_W-1:0] = filt_len. Writes are byte-enable qualified; unused bits read 0.
  - addr 2 (RO): {28'b0, dir, Z_out, B_out, A_out}.
  - addr 3: err_cnt, 16-bit, zero-extended on read. A write of any data clears it. It increments on each err and saturates at 16'hFFFF. If a clear coincides with an increment, the clear wins and the result is 0.
  - addr 4–7: read 0; writes are ignored.
- A filt_len write takes effect on the next comparison. An in-flight counter already above the new value is compared with equality, wraps, and then settles. This is acceptable and not required to be prevented.
- Reset mid-operation clears everything immediately. No step is generated by the reset release.

Decomposition:
- Shared package:
  - Register address constants QIF_ADDR_ID/CTRL/STAT/ERR.
  - Control bit positions QIF_CTRL_EN_BIT.
  - The encoder ID family prefix 16'hEA68.
- Sub-module qif_glitch_filter: a 2-FF synchroniser plus the counter filter for one channel, instantiated 3 times. Ports: clk, rst, en, filt_len, raw, out.
- The decoder and register file stay in the top module.

Test Plan:
- Reset, then read addr 0, 1, 2 → 0xEA680004, 0x80000003, 0x0. Outputs are 0.
- filt_len = 3, forward sequence with 20-cycle phases (A↑, B↑, A↓, B↓) → 4 step pulses, dir = 1. Each A_out edge appears 6 cycles after its raw edge.
- Reverse sequence of 8 edges → 8 steps, dir = 0. addr 2 tracks the pin levels.
- filt_len = 3, 3-cycle glitches on A_in → no A_out change, no step. Then a 4-cycle pulse → A_out toggles.
- filt_len = 0, A and B toggled in the same cycle → err pulse, err_cnt = 1. Then a write to addr 3 coinciding with a second err → err_cnt = 0.
- Write enable = 0 mid-sequence, toggle pins, then re-enable → no step or err while disabled or on the re-enable cycle. Then a normal step resumes.
